instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 53 +++++
 rtl/instr_encoder.sv | 210 +++++++++++++++++++++
 tb/tb_instr_encoder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
//   Bundles the request handshake, request fields, instruction-memory write
//   port and status flags of instr_encoder.
//
//   master modport : request producer (drives request fields and clear,
//                    observes handshake, memory write port and status)
//   slave modport  : the encoder itself
//
//   Signals
//     req_valid   1   encode request present
//     req_ready   1   encoder can accept a request this cycle
//     req_kind    3   0=R-type 1=addi 2=lw 3=sw 4=beq 5=j, 6/7 illegal
//     rs, rt, rd  5   register fields
//     funct       6   R-type function field
//     imm         16  immediate / offset (addi, lw, sw, beq)
//     target      26  jump target (j)
//     clear       1   rewind write pointer, clear count and full
//     imem_we     1   one-cycle instruction-memory write strobe
//     imem_addr   6   word address of the current write
//     imem_wdata  32  encoded MIPS instruction word
//     count       7   words written since reset or clear (0..64)
//     full        1   all 64 locations written
//     err_illegal 1   sticky: an illegal req_kind was accepted
// -----------------------------------------------------------------------------
interface instr_encoder_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_kind;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] target;
   logic        clear;
   logic        imem_we;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [6:0]  count;
   logic        full;
   logic        err_illegal;

   modport master (
      output req_valid, req_kind, rs, rt, rd, funct, imm, target, clear,
      input  req_ready, imem_we, imem_addr, imem_wdata, count, full, err_illegal
   );

   modport slave (
      input  req_valid, req_kind, rs, rt, rd, funct, imm, target, clear,
      output req_ready, imem_we, imem_addr, imem_wdata, count, full, err_illegal
   );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Accepts one encode request at a time, builds the 32-bit MIPS instruction
//   word for it and writes that word into a 64-entry instruction memory at
//   consecutive word addresses. One request is processed per three cycles:
//     IDLE  : ready; latch request fields on req_valid (clear has priority)
//     ENC   : build the instruction word into the output data register, or
//             flag an illegal kind and drop the request
//     WRITE : pulse imem_we for one cycle, advance pointer and count
//     FULL  : all 64 words written; requests ignored until clear or reset
//
//   Ports
//     clk    input   sole clock, rising edge
//     reset  input   synchronous active-high reset
//     bus    slave   request fields, handshake, memory write port, status
// -----------------------------------------------------------------------------
module instr_encoder (
   input  logic           clk,
   input  logic           reset,
   instr_encoder_if.slave bus
);

   // Request kinds
   localparam logic [2:0] KIND_RTYPE = 3'd0;
   localparam logic [2:0] KIND_ADDI  = 3'd1;
   localparam logic [2:0] KIND_LW    = 3'd2;
   localparam logic [2:0] KIND_SW    = 3'd3;
   localparam logic [2:0] KIND_BEQ   = 3'd4;
   localparam logic [2:0] KIND_J     = 3'd5;

   // MIPS primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] LAST_ADDR = 6'd63;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENC,
      S_WRITE,
      S_FULL
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Request fields captured at acceptance
   logic [2:0]  kind_q;
   logic [4:0]  rs_q;
   logic [4:0]  rt_q;
   logic [4:0]  rd_q;
   logic [5:0]  funct_q;
   logic [15:0] imm_q;
   logic [25:0] target_q;

   logic [5:0]  wr_ptr;
   logic [6:0]  count_q;
   logic        err_q;
   logic [5:0]  addr_q;
   logic [31:0] wdata_q;

   logic        accept;
   logic        kind_legal;
   logic [31:0] enc_word;

   assign accept     = (state == S_IDLE) && bus.req_valid && !bus.clear;
   assign kind_legal = (kind_q <= KIND_J);

   // Instruction word built from the latched request fields
   always_comb begin
      enc_word = '0;
      case (kind_q)
         KIND_RTYPE: enc_word = {OP_RTYPE, rs_q, rt_q, rd_q, 5'b00000, funct_q};
         KIND_ADDI:  enc_word = {OP_ADDI, rs_q, rt_q, imm_q};
         KIND_LW:    enc_word = {OP_LW, rs_q, rt_q, imm_q};
         KIND_SW:    enc_word = {OP_SW, rs_q, rt_q, imm_q};
         KIND_BEQ:   enc_word = {OP_BEQ, rs_q, rt_q, imm_q};
         KIND_J:     enc_word = {OP_J, target_q};
         default:    enc_word = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_ENC;
            end
         end
         S_ENC: begin
            state_nxt = kind_legal ? S_WRITE : S_IDLE;
         end
         S_WRITE: begin
            state_nxt = (wr_ptr == LAST_ADDR) ? S_FULL : S_IDLE;
         end
         S_FULL: begin
            if (bus.clear) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.req_ready = 1'b0;
      bus.imem_we   = 1'b0;
      bus.full      = 1'b0;
      case (state)
         S_IDLE:  bus.req_ready = 1'b1;
         // Reset is synchronous, so the state is still WRITE during the cycle
         // in which reset is asserted; gating the strobe keeps an aborted
         // write from reaching memory.
         S_WRITE: bus.imem_we   = !reset;
         S_FULL:  bus.full      = 1'b1;
         default: ;
      endcase
   end

   assign bus.imem_addr   = addr_q;
   assign bus.imem_wdata  = wdata_q;
   assign bus.count       = count_q;
   assign bus.err_illegal = err_q;

   // ---------------------------------------------------------------------------
   // Request capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         kind_q   <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         funct_q  <= '0;
         imm_q    <= '0;
         target_q <= '0;
      end else if (accept) begin
         kind_q   <= bus.req_kind;
         rs_q     <= bus.rs;
         rt_q     <= bus.rt;
         rd_q     <= bus.rd;
         funct_q  <= bus.funct;
         imm_q    <= bus.imm;
         target_q <= bus.target;
      end
   end

   // ---------------------------------------------------------------------------
   // Write pointer, count, error flag and memory write port registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state)
            S_IDLE, S_FULL: begin
               if (bus.clear) begin
                  wr_ptr  <= '0;
                  count_q <= '0;
               end
            end
            S_ENC: begin
               // Address and data are loaded on the way into WRITE so they are
               // stable for the whole strobe cycle and hold afterwards.
               if (kind_legal) begin
                  wdata_q <= enc_word;
                  addr_q  <= wr_ptr;
               end else begin
                  err_q <= 1'b1;
               end
            end
            S_WRITE: begin
               count_q <= count_q + 7'd1;
               // Pointer parks at 63 once the last word is written.
               if (wr_ptr != LAST_ADDR) begin
                  wr_ptr <= wr_ptr + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   instr_encoder_if bus ();

   instr_encoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: number of words written since reset/clear, sticky error
   int unsigned exp_count;
   logic        exp_err;

   // Current request fields
   int unsigned cur_kind, cur_rs, cur_rt, cur_rd, cur_funct, cur_imm, cur_target;

   // Instruction word from the field layout, by place-value arithmetic
   function automatic logic [31:0] model_word(input int unsigned kind, rs_v, rt_v,
                                              rd_v, fn, im, tg);
      int unsigned op;
      case (kind)
         0: return rs_v * 2097152 + rt_v * 65536 + rd_v * 2048 + fn;
         1: op = 8;
         2: op = 35;
         3: op = 43;
         4: op = 4;
         5: return 2 * 67108864 + tg;
         default: return 32'd0;
      endcase
      return op * 67108864 + rs_v * 2097152 + rt_v * 65536 + im;
   endfunction

   task automatic set_fields(input int unsigned k, rs_v, rt_v, rd_v, fn, im, tg);
      cur_kind = k; cur_rs = rs_v; cur_rt = rt_v; cur_rd = rd_v;
      cur_funct = fn; cur_imm = im; cur_target = tg;
   endtask

   task automatic random_fields(input int unsigned max_kind);
      set_fields($urandom_range(0, max_kind), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                 $urandom_range(0, 67108863));
   endtask

   task automatic drive_fields();
      bus.req_kind = cur_kind[2:0];
      bus.rs       = cur_rs[4:0];
      bus.rt       = cur_rt[4:0];
      bus.rd       = cur_rd[4:0];
      bus.funct    = cur_funct[5:0];
      bus.imm      = cur_imm[15:0];
      bus.target   = cur_target[25:0];
   endtask

   // Presents the current request for one cycle; returns at the falling edge
   // after the accepting edge (encoder is then in its encode cycle).
   task automatic issue();
      @(negedge clk);
      drive_fields();
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      exp_count = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req_valid = 1'b0; bus.clear = 1'b0;
      set_fields(0, 0, 0, 0, 0, 0, 0);
      drive_fields();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_count = 0; exp_err = 1'b0;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
      checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.imem_we); end
      checks++; if (bus.imem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.imem_addr); end
      checks++; if (bus.imem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.imem_wdata); end
      checks++; if (bus.count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
      checks++; if (bus.err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_illegal); end
   endtask

   task automatic test_rtype();
      set_fields(0, 1, 2, 3, 32'h20, 0, 0);
      issue();
      checks++; if (bus.req_ready !== 1'b0 || bus.imem_we !== 1'b0) begin errors++; $display("FAIL rtype_enc: ready=%b we=%b expected 0 0", bus.req_ready, bus.imem_we); end
      @(negedge clk);
      checks++; if (bus.imem_we !== 1'b1) begin errors++; $display("FAIL rtype_we: got %b expected 1", bus.imem_we); end
      checks++; if (bus.imem_addr !== 6'd0) begin errors++; $display("FAIL rtype_addr: got %0d expected 0", bus.imem_addr); end
      checks++; if (bus.imem_wdata !== 32'h00221820) begin errors++; $display("FAIL rtype_wdata: got %h expected 00221820", bus.imem_wdata); end
      @(negedge clk);
      exp_count = 1;
      checks++; if (bus.count !== 7'd1 || bus.req_ready !== 1'b1 || bus.imem_we !== 1'b0) begin errors++; $display("FAIL rtype_after: count=%0d ready=%b we=%b expected 1 1 0", bus.count, bus.req_ready, bus.imem_we); end
   endtask

   task automatic test_addi_j();
      logic [31:0] words [2];
      words[0] = 32'h20080005;
      words[1] = 32'h08000010;
      do_clear();
      for (int i = 0; i < 2; i++) begin
         if (i == 0) set_fields(1, 0, 8, 0, 0, 16'h0005, 0);
         else        set_fields(5, 0, 0, 0, 0, 0, 26'h0000010);
         issue();
         checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL addij_ready1[%0d]: got %b expected 0", i, bus.req_ready); end
         @(negedge clk);
         checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL addij_ready2[%0d]: got %b expected 0", i, bus.req_ready); end
         checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== i[5:0] || bus.imem_wdata !== words[i]) begin
            errors++; $display("FAIL addij_write[%0d]: we=%b addr=%0d data=%h expected 1 %0d %h", i, bus.imem_we, bus.imem_addr, bus.imem_wdata, i, words[i]);
         end
         @(negedge clk);
         exp_count++;
         checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL addij_ready3[%0d]: got %b expected 1", i, bus.req_ready); end
      end
   endtask

   task automatic test_illegal();
      set_fields(7, 4, 5, 6, 7, 16'h1234, 0);
      issue();
      checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL ill_we_enc: got %b expected 0", bus.imem_we); end
      @(negedge clk);
      exp_err = 1'b1;
      checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL ill_we_next: got %b expected 0", bus.imem_we); end
      checks++; if (bus.err_illegal !== 1'b1) begin errors++; $display("FAIL ill_err: got %b expected 1", bus.err_illegal); end
      checks++; if (bus.count !== exp_count[6:0]) begin errors++; $display("FAIL ill_count: got %0d expected %0d", bus.count, exp_count); end
      set_fields(2, 9, 10, 0, 0, 16'hfffc, 0);
      issue();
      @(negedge clk);
      checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== exp_count[5:0] || bus.imem_wdata !== 32'h8d2afffc) begin
         errors++; $display("FAIL ill_next_write: we=%b addr=%0d data=%h expected 1 %0d 8d2afffc", bus.imem_we, bus.imem_addr, bus.imem_wdata, exp_count);
      end
      @(negedge clk);
      exp_count++;
      checks++; if (bus.err_illegal !== 1'b1 || bus.count !== exp_count[6:0]) begin errors++; $display("FAIL ill_sticky: err=%b count=%0d expected 1 %0d", bus.err_illegal, bus.count, exp_count); end
   endtask

   // Random kinds and fields; legal ones sometimes carry clear during the
   // in-flight cycles, which must not disturb the write.
   task automatic test_random();
      logic [31:0] exp_word;
      bit          hold_clear;
      for (int i = 0; i < 24; i++) begin
         random_fields(7);
         hold_clear = ($urandom_range(0, 3) == 0);
         issue();
         checks++; if (bus.req_ready !== 1'b0 || bus.imem_we !== 1'b0) begin errors++; $display("FAIL rnd_enc[%0d]: ready=%b we=%b expected 0 0", i, bus.req_ready, bus.imem_we); end
         if (cur_kind <= 5) begin
            exp_word = model_word(cur_kind, cur_rs, cur_rt, cur_rd, cur_funct, cur_imm, cur_target);
            bus.clear = hold_clear;
            @(negedge clk);
            checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== exp_count[5:0] || bus.imem_wdata !== exp_word) begin
               errors++; $display("FAIL rnd_write[%0d]: we=%b addr=%0d data=%h expected 1 %0d %h", i, bus.imem_we, bus.imem_addr, bus.imem_wdata, exp_count, exp_word);
            end
            @(negedge clk);
            bus.clear = 1'b0;
            exp_count++;
         end else begin
            @(negedge clk);
            exp_err = 1'b1;
            checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL rnd_ill_we[%0d]: got %b expected 0", i, bus.imem_we); end
         end
         checks++; if (bus.count !== exp_count[6:0] || bus.err_illegal !== exp_err || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rnd_status[%0d]: count=%0d err=%b ready=%b expected %0d %b 1", i, bus.count, bus.err_illegal, bus.req_ready, exp_count, exp_err);
         end
      end
   endtask

   // req_valid held high throughout: one word every three cycles until full
   task automatic test_back_to_back_fill();
      logic [31:0] exp_word;
      do_clear();
      bus.req_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         random_fields(5);
         drive_fields();
         exp_word = model_word(cur_kind, cur_rs, cur_rt, cur_rd, cur_funct, cur_imm, cur_target);
         checks++; if (bus.req_ready !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL fill_ready[%0d]: ready=%b full=%b expected 1 0", i, bus.req_ready, bus.full); end
         @(negedge clk);
         @(negedge clk);
         checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== i[5:0] || bus.imem_wdata !== exp_word) begin
            errors++; $display("FAIL fill_write[%0d]: we=%b addr=%0d data=%h expected 1 %0d %h", i, bus.imem_we, bus.imem_addr, bus.imem_wdata, i, exp_word);
         end
         @(negedge clk);
         exp_count++;
      end
      checks++; if (bus.full !== 1'b1 || bus.count !== 7'd64 || bus.req_ready !== 1'b0) begin
         errors++; $display("FAIL fill_full: full=%b count=%0d ready=%b expected 1 64 0", bus.full, bus.count, bus.req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (bus.imem_we !== 1'b0 || bus.full !== 1'b1 || bus.count !== 7'd64) begin
            errors++; $display("FAIL fill_ignore[%0d]: we=%b full=%b count=%0d expected 0 1 64", i, bus.imem_we, bus.full, bus.count);
         end
      end
      bus.req_valid = 1'b0;
      do_clear();
      checks++; if (bus.full !== 1'b0 || bus.count !== 7'd0 || bus.req_ready !== 1'b1) begin
         errors++; $display("FAIL fill_clear: full=%b count=%0d ready=%b expected 0 0 1", bus.full, bus.count, bus.req_ready);
      end
      set_fields(4, 3, 4, 0, 0, 16'h0010, 0);
      issue();
      @(negedge clk);
      checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 6'd0 || bus.imem_wdata !== 32'h10640010) begin
         errors++; $display("FAIL fill_rewrite: we=%b addr=%0d data=%h expected 1 0 10640010", bus.imem_we, bus.imem_addr, bus.imem_wdata);
      end
      @(negedge clk);
      exp_count = 1;
   endtask

   task automatic test_clear_collision();
      set_fields(0, 5, 6, 7, 8, 0, 0);
      @(negedge clk);
      drive_fields();
      bus.clear = 1'b1;
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      bus.req_valid = 1'b0;
      exp_count = 0;
      checks++; if (bus.req_ready !== 1'b1 || bus.count !== 7'd0) begin errors++; $display("FAIL coll_state: ready=%b count=%0d expected 1 0", bus.req_ready, bus.count); end
      @(negedge clk);
      checks++; if (bus.imem_we !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL coll_noaccept: we=%b ready=%b expected 0 1", bus.imem_we, bus.req_ready); end
      issue();
      @(negedge clk);
      checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 6'd0) begin errors++; $display("FAIL coll_addr: we=%b addr=%0d expected 1 0", bus.imem_we, bus.imem_addr); end
      @(negedge clk);
      exp_count = 1;
   endtask

   task automatic test_reset_in_write();
      set_fields(0, 31, 30, 29, 63, 0, 0);
      issue();
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL rstw_we: got %b expected 0", bus.imem_we); end
      @(negedge clk);
      exp_count = 0; exp_err = 1'b0;
      checks++; if (bus.imem_addr !== 6'd0 || bus.imem_wdata !== 32'd0 || bus.count !== 7'd0) begin
         errors++; $display("FAIL rstw_regs: addr=%0d data=%h count=%0d expected 0 0 0", bus.imem_addr, bus.imem_wdata, bus.count);
      end
      checks++; if (bus.err_illegal !== 1'b0 || bus.full !== 1'b0 || bus.req_ready !== 1'b1 || bus.imem_we !== 1'b0) begin
         errors++; $display("FAIL rstw_flags: err=%b full=%b ready=%b we=%b expected 0 0 1 0", bus.err_illegal, bus.full, bus.req_ready, bus.imem_we);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("FAIL rstw_late_we[%0d]: got %b expected 0", i, bus.imem_we); end
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_addi_j();
      test_illegal();
      test_random();
      test_back_to_back_fill();
      test_clear_collision();
      test_reset_in_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
